serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial unsigned adder. It consumes the sum/carry outputs of a one-bit adder cell once per clock. It loads two WIDTH-bit operands, adds them LSB-first over WIDTH cycles through a registered carry, then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits downstream of the combinational adder cells and is the first clocked arithmetic stage in the library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin an addition; sampled only when accepting (IDLE or DONE).
a  input  WIDTH  operand A; sampled on the accepted-start edge only.
b  input  WIDTH  operand B; sampled on the accepted-start edge only.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; sum/carry valid from this cycle.
sum  output  WIDTH  registered result, held until the next completion.
carry  output  1  registered carry-out of bit WIDTH-1, held with sum.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on rst, applied at any state including mid-RUN. Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0. All internal shift registers, the counter and the carry flop are cleared.
- States:
  - IDLE: wait.
  - RUN: one bit per cycle.
  - DONE: single cycle.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(cnt==WIDTH-1)--> DONE.
  - DONE --start--> RUN.
  - DONE --!start--> IDLE.
- Accepted start, in IDLE or DONE:
  - sa<=a, sb<=b.
  - carry flop c<=0, cnt<=0, partial-sum register ps<=0.
- Each RUN cycle:
  - Combinational bit add of sa[0], sb[0], c: s=sa[0]^sb[0]^c; co=majority.
  - c<=co.
  - sa and sb shift right by one, zero-filled.
  - ps shifts right with s entering at bit WIDTH-1.
  - cnt<=cnt+1.
- Final RUN cycle (cnt==WIDTH-1):
  - sum<={s, ps[WIDTH-1:1]}, i.e. the fully shifted result including this cycle's bit.
  - carry<=co.
  - Next state DONE.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- Latency: start accepted at edge T -> done high during cycle after edge T+WIDTH. That is WIDTH RUN cycles, then DONE.
- start while busy=1 is ignored; a/b changes during RUN have no effect.
- sum/carry update only on the final RUN edge. They keep the previous result throughout a new RUN.
- Back-to-back: start asserted during DONE begins the next addition with no IDLE cycle. Throughput is one result per WIDTH+1 cycles.
- cnt width = $clog2(WIDTH+1).
- WIDTH=1: RUN lasts one cycle; cnt==0 is the final cycle.
- Arithmetic is modulo 2^WIDTH with carry as bit WIDTH. Result equals a+b as a WIDTH+1-bit number {carry,sum}.

Decomposition:
- Shared package: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, plus a WIDTH range check constant.
- One natural sub-module: fa_cell, a combinational one-bit full adder. Ports: x, y, cin, s, co. It is built from two half-adder stages plus an OR for the carry, and is instantiated once for the serial datapath.
- FSM, shift registers and counter stay in serial_adder.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, start pulsed at edge T -> busy high for 8 cycles; done at T+9 with sum=0x8D, carry=0.
- a=0xFF, b=0x01 -> sum=0x00, carry=1. a=0xFF, b=0xFF -> sum=0xFE, carry=1. a=0, b=0 -> sum=0, carry=0.
- a=0x0F, b=0x01, then during RUN drive start=1 with a=0xAA, b=0x55 -> ignored. Result sum=0x10, carry=0; previous sum held until completion.
- rst asserted at 4th RUN cycle -> next cycle busy=0, done=0, sum=0, carry=0, IDLE. A new start of 0x80+0x80 then gives sum=0x00, carry=1.
- start held during DONE with a=0x01, b=0x02 -> RUN entered immediately. Second done exactly 9 cycles after the first, sum=0x03.
- WIDTH=1: a=1, b=1 -> one RUN cycle, done at T+2, sum=0, carry=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  // True when an operand width falls inside the supported range.
  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder: two half-adder stages, carries ORed.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p, g1, g2;

  // first half adder on the operands, second folds in the carry
  always_comb begin
    p  = x ^ y;
    g1 = x & y;
    s  = p ^ cin;
    g2 = p & cin;
    co = g1 | g2;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ps, ps_nxt;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s, co;
  logic             load, step, last;

  fa_cell u_fa (
    .x  (sa[0]),
    .y  (sb[0]),
    .cin(c),
    .s  (s),
    .co (co)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and datapath strobes; starts are only honoured outside RUN
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // partial sum after this cycle's bit enters at the top (works for WIDTH=1)
  always_comb begin
    ps_nxt            = ps >> 1;
    ps_nxt[WIDTH-1]   = s;
  end

  // operand shifters, carry flop, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      ps  <= '0;
      cnt <= '0;
      c   <= 1'b0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      ps  <= ps_nxt;
      cnt <= cnt + 1'b1;
      c   <= co;
      if (last) begin
        sum   <= ps_nxt;
        carry <= co;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
